// File: rtl/ps2_device_port.sv
`timescale 1ns/1ps
// ps2_device_port
// Device-side PS/2 link engine. The device always generates PS2_CLK. It sends
// device-to-host bytes (ACKs, movement packets) and receives host commands
// announced by the host request-to-send (clock released while data is held low).
//
// Ports
//   clk, rst_n         system clock, asynchronous active-low reset
//   tx_data/tx_valid   byte to send; accepted when tx_valid && tx_ready
//   tx_ready           one-byte buffer empty and engine idle
//   tx_done            pulse: frame finished (stop bit clocked)
//   tx_abort           pulse: host inhibit cut a frame short; byte kept for retry
//   rx_data            last host command received with good parity
//   rx_valid           pulse: rx_data updated
//   rx_error           pulse: parity or stop-bit error on a host command
//   PS2_CLK, PS2_DAT   open-drain lines, driven 0 or released ('z) only
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// S_IDLE    | lines released; watch for host RTS, else start a pending byte
// S_TX_BIT  | clocking out the 11-bit frame, bit_idx 0..10
// S_RX_BIT  | clocking in host bits: pulses 0-7 data, 8 parity, 9 stop
// S_RX_ACK  | pulse 10 with PS2_DAT held low as the acknowledge
// S_RX_WAIT | ACK released; wait for the data line to read high again
module ps2_device_port #(
    parameter int CLK_HALF    = 2000,
    parameter int IDLE_CYCLES = 2500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_abort,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_error,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT
);

    localparam int HW = $clog2(CLK_HALF + 1);
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam logic [HW-1:0] HALF_LOAD = HW'(CLK_HALF - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_BIT,
        S_RX_BIT,
        S_RX_ACK,
        S_RX_WAIT
    } state_t;

    state_t        state;
    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_s;
    logic          dat_s;
    logic [HW-1:0] half_cnt;
    logic          half_hi;     // 0: released-clock half, 1: clock-low half
    logic [3:0]    bit_idx;
    logic [IW-1:0] idle_cnt;
    logic [7:0]    tx_buf;
    logic          buf_full;
    logic [8:0]    rx_shift;    // {parity, data[7:0]} once nine bits are in
    logic          rx_stop;
    logic          clk_low;
    logic          dat_low;

    logic          half_end;
    logic [3:0]    nxt_idx;
    logic [15:0]   tx_frame;
    logic          rx_par_ok;
    logic          accept;

    // Open-drain pads: only ever pull low or let go.
    assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

    assign clk_s     = clk_sync[1];
    assign dat_s     = dat_sync[1];
    assign half_end  = (half_cnt == '0);
    assign nxt_idx   = bit_idx + 4'd1;
    // Frame LSB-first: start 0, data, odd parity, stop 1; upper bits pad to a
    // power of two so any 4-bit index lands on a released (1) level.
    assign tx_frame  = {5'b11111, 1'b1, ~^tx_buf, tx_buf, 1'b0};
    assign rx_par_ok = ^rx_shift;
    assign accept    = tx_valid && tx_ready;

    // Line synchronisers. Idle level of both lines is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DAT};
        end
    end

    // Consecutive both-lines-high clocks, saturating at IDLE_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!(clk_s && dat_s)) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            half_cnt <= '0;
            half_hi  <= 1'b0;
            bit_idx  <= '0;
            tx_buf   <= '0;
            buf_full <= 1'b0;
            rx_shift <= '0;
            rx_stop  <= 1'b0;
            clk_low  <= 1'b0;
            dat_low  <= 1'b0;
            tx_ready <= 1'b0;
            tx_done  <= 1'b0;
            tx_abort <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_abort <= 1'b0;
            rx_valid <= 1'b0;
            rx_error <= 1'b0;

            // tx_ready is only ever high in S_IDLE with an empty buffer, so an
            // accepted byte can never collide with a frame in flight.
            if (accept) begin
                tx_buf   <= tx_data;
                buf_full <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    clk_low <= 1'b0;
                    dat_low <= 1'b0;
                    if (clk_s && !dat_s) begin
                        state    <= S_RX_BIT;
                        bit_idx  <= '0;
                        half_hi  <= 1'b0;
                        half_cnt <= HALF_LOAD;
                        tx_ready <= 1'b0;
                    end else if (buf_full && idle_cnt >= IDLE_MAX) begin
                        state    <= S_TX_BIT;
                        bit_idx  <= '0;
                        half_hi  <= 1'b0;
                        half_cnt <= HALF_LOAD;
                        dat_low  <= ~tx_frame[0];
                        tx_ready <= 1'b0;
                    end else begin
                        tx_ready <= !buf_full && !accept;
                    end
                end

                S_TX_BIT: begin
                    if (!half_end) begin
                        half_cnt <= half_cnt - HW'(1);
                    end else begin
                        half_cnt <= HALF_LOAD;
                        if (!half_hi) begin
                            // Host holding the clock low while we release it
                            // is an inhibit; the stop bit is past the point of
                            // no return.
                            if (!clk_s && bit_idx < 4'd10) begin
                                state    <= S_IDLE;
                                clk_low  <= 1'b0;
                                dat_low  <= 1'b0;
                                tx_abort <= 1'b1;
                            end else begin
                                half_hi <= 1'b1;
                                clk_low <= 1'b1;
                            end
                        end else begin
                            half_hi <= 1'b0;
                            clk_low <= 1'b0;
                            if (bit_idx == 4'd10) begin
                                state    <= S_IDLE;
                                dat_low  <= 1'b0;
                                buf_full <= 1'b0;
                                tx_done  <= 1'b1;
                                tx_ready <= 1'b1;
                            end else begin
                                bit_idx <= nxt_idx;
                                dat_low <= ~tx_frame[nxt_idx];
                            end
                        end
                    end
                end

                S_RX_BIT: begin
                    if (!half_end) begin
                        half_cnt <= half_cnt - HW'(1);
                    end else begin
                        half_cnt <= HALF_LOAD;
                        if (!half_hi) begin
                            if (!clk_s) begin
                                state    <= S_IDLE;
                                clk_low  <= 1'b0;
                                dat_low  <= 1'b0;
                                tx_ready <= !buf_full;
                            end else begin
                                if (bit_idx == 4'd9) begin
                                    rx_stop <= dat_s;
                                end else begin
                                    rx_shift <= {dat_s, rx_shift[8:1]};
                                end
                                half_hi <= 1'b1;
                                clk_low <= 1'b1;
                            end
                        end else begin
                            half_hi <= 1'b0;
                            clk_low <= 1'b0;
                            bit_idx <= nxt_idx;
                            if (bit_idx == 4'd9) begin
                                if (rx_stop) begin
                                    state   <= S_RX_ACK;
                                    dat_low <= 1'b1;
                                end else begin
                                    state    <= S_IDLE;
                                    rx_error <= 1'b1;
                                    tx_ready <= !buf_full;
                                end
                            end
                        end
                    end
                end

                S_RX_ACK: begin
                    if (!half_end) begin
                        half_cnt <= half_cnt - HW'(1);
                    end else begin
                        half_cnt <= HALF_LOAD;
                        if (!half_hi) begin
                            half_hi <= 1'b1;
                            clk_low <= 1'b1;
                        end else begin
                            half_hi <= 1'b0;
                            clk_low <= 1'b0;
                            dat_low <= 1'b0;
                            state   <= S_RX_WAIT;
                            if (rx_par_ok) begin
                                rx_data  <= rx_shift[7:0];
                                rx_valid <= 1'b1;
                            end else begin
                                rx_error <= 1'b1;
                            end
                        end
                    end
                end

                S_RX_WAIT: begin
                    if (dat_s) begin
                        state    <= S_IDLE;
                        tx_ready <= !buf_full;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    clk_low <= 1'b0;
                    dat_low <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_device_port.sv
`timescale 1ns/1ps
module tb_ps2_device_port;

    localparam int CLK_HALF    = 4;
    localparam int IDLE_CYCLES = 6;
    localparam logic [10:0] FRAME_FA = 11'h7F4; // 0xFA, parity 1, LSB first

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_abort;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    wire        ps2_clk;
    wire        ps2_dat;
    logic       host_clk_low;
    logic       host_dat_low;

    int checks   = 0;
    int failures = 0;
    int n_done   = 0;
    int n_abort  = 0;
    int n_rxv    = 0;
    int n_rxe    = 0;
    logic bit_q[$];
    time  time_q[$];

    always #5 clk = ~clk;

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = host_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = host_dat_low ? 1'b0 : 1'bz;

    ps2_device_port #(.CLK_HALF(CLK_HALF), .IDLE_CYCLES(IDLE_CYCLES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .tx_abort (tx_abort),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_error (rx_error),
        .PS2_CLK  (ps2_clk),
        .PS2_DAT  (ps2_dat)
    );

    always @(negedge clk) begin
        if (tx_done)  n_done  = n_done + 1;
        if (tx_abort) n_abort = n_abort + 1;
        if (rx_valid) n_rxv   = n_rxv + 1;
        if (rx_error) n_rxe   = n_rxe + 1;
    end

    // Host-side view: data is read on each falling clock edge.
    always @(negedge ps2_clk) begin
        bit_q.push_back(ps2_dat);
        time_q.push_back($time);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        bit_q.delete();
        time_q.delete();
    endtask

    task automatic wait_fall(input int limit, output bit ok);
        logic prev;
        prev = ps2_clk;
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(posedge clk);
            #2;
            if (prev === 1'b1 && ps2_clk === 1'b0) ok = 1'b1;
            prev = ps2_clk;
        end
    endtask

    task automatic wait_rise(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(posedge clk);
            #2;
            if (ps2_clk === 1'b1) ok = 1'b1;
        end
    endtask

    // which: 0 tx_done, 1 tx_abort, 2 rx_valid or rx_error
    task automatic wait_cnt(input int which, input int start, input int limit, output bit ok);
        int cur;
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(posedge clk);
            #1;
            case (which)
                0:       cur = n_done;
                1:       cur = n_abort;
                default: cur = n_rxv + n_rxe;
            endcase
            if (cur != start) ok = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        tx_data  = b;
        tx_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (tx_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    // Host command: inhibit, pull data low, release clock, then present each
    // next bit after every device falling edge. The request level doubles as
    // data bit 0, so commands sent here have bit 0 clear.
    task automatic host_send(input logic [7:0] d, input bit bad_par, input bit with_tx,
                             output int pulses, output logic ack, output bit ok);
        logic [9:0] bits;
        bit fell;
        bits = {1'b1, (~^d) ^ bad_par, d};
        host_clk_low = 1'b1;
        tick(12);
        host_dat_low = 1'b1;
        tick(2);
        host_clk_low = 1'b0;
        if (with_tx) begin
            tx_data  = 8'hFA;
            tx_valid = 1'b1;
            tick(1);
            tx_valid = 1'b0;
        end
        pulses = 0;
        ack = 1'b1;
        fell = 1'b1;
        for (int k = 0; k < 11 && fell; k++) begin
            wait_fall(40, fell);
            if (fell) begin
                pulses = pulses + 1;
                if (k < 9) host_dat_low = ~bits[k+1];
                else       host_dat_low = 1'b0;
                if (k == 10) ack = ps2_dat;
            end
        end
        host_dat_low = 1'b0;
        wait_cnt(2, n_rxv + n_rxe, 40, ok);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        host_clk_low = 1'b0;
        host_dat_low = 1'b0;
        tick(3);
        checks++;
        if ({tx_ready, tx_done, tx_abort, rx_valid, rx_error} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=00000",
                     {tx_ready, tx_done, tx_abort, rx_valid, rx_error});
        end
        checks++;
        if (rx_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_rx_data got=%h want=00", rx_data);
        end
        checks++;
        if ({ps2_clk, ps2_dat} !== 2'b11) begin
            failures++;
            $display("FAIL reset_lines got=%b want=11", {ps2_clk, ps2_dat});
        end
        rst_n = 1'b1;
        tick(4);
        checks++;
        if (tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_after got=%b want=1", tx_ready);
        end
    endtask

    task automatic test_tx_basic();
        bit ok;
        int d0;
        logic [10:0] got;
        bit spacing_ok;
        d0 = n_done;
        clear_q();
        send_byte(8'hFA, ok);
        checks++;
        if (!ok || tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL tx_accept ok=%0d ready_after=%b want ok=1 ready=0", ok, tx_ready);
        end
        wait_cnt(0, d0, 300, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL tx_done_timeout got=none want=pulse");
        end
        got = '0;
        for (int i = 0; i < 11 && i < bit_q.size(); i++) got[i] = bit_q[i];
        checks++;
        if (bit_q.size() != 11 || got !== FRAME_FA) begin
            failures++;
            $display("FAIL tx_frame bits=%0d got=%b want=11 %b", bit_q.size(), got, FRAME_FA);
        end
        spacing_ok = 1'b1;
        for (int i = 1; i < time_q.size(); i++)
            if (time_q[i] - time_q[i-1] != 80) spacing_ok = 1'b0;
        checks++;
        if (!spacing_ok) begin
            failures++;
            $display("FAIL tx_bit_period got=uneven want=80ns");
        end
        tick(30);
        checks++;
        if (n_done - d0 != 1 || tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL tx_done_once done=%0d ready=%b want=1 1", n_done - d0, tx_ready);
        end
    endtask

    task automatic test_rx_ok();
        int pulses;
        logic ack;
        bit ok;
        int v0, e0;
        v0 = n_rxv;
        e0 = n_rxe;
        host_send(8'hF4, 1'b0, 1'b0, pulses, ack, ok);
        checks++;
        if (!ok || pulses != 11) begin
            failures++;
            $display("FAIL rx_pulses got=%0d done=%0d want=11 1", pulses, ok);
        end
        checks++;
        if (ack !== 1'b0) begin
            failures++;
            $display("FAIL rx_ack got=%b want=0", ack);
        end
        checks++;
        if (n_rxv - v0 != 1 || n_rxe != e0 || rx_data !== 8'hF4) begin
            failures++;
            $display("FAIL rx_f4 valid=%0d err=%0d data=%h want=1 0 f4",
                     n_rxv - v0, n_rxe - e0, rx_data);
        end
        tick(20);
    endtask

    task automatic test_rts_priority();
        int pulses;
        logic ack;
        bit ok;
        int v0, d0;
        logic [10:0] got;
        v0 = n_rxv;
        d0 = n_done;
        host_send(8'h00, 1'b0, 1'b1, pulses, ack, ok);
        checks++;
        if (!ok || n_rxv - v0 != 1 || rx_data !== 8'h00 || pulses != 11) begin
            failures++;
            $display("FAIL rts_rx_first valid=%0d data=%h pulses=%0d want=1 00 11",
                     n_rxv - v0, rx_data, pulses);
        end
        checks++;
        if (n_done != d0) begin
            failures++;
            $display("FAIL rts_tx_early done=%0d want=0", n_done - d0);
        end
        clear_q();
        wait_cnt(0, d0, 300, ok);
        got = '0;
        for (int i = 0; i < 11 && i < bit_q.size(); i++) got[i] = bit_q[i];
        checks++;
        if (!ok || bit_q.size() != 11 || got !== FRAME_FA) begin
            failures++;
            $display("FAIL rts_tx_after done=%0d bits=%0d got=%b want=1 11 %b",
                     ok, bit_q.size(), got, FRAME_FA);
        end
        tick(20);
    endtask

    task automatic test_rx_parity_error();
        int pulses;
        logic ack;
        bit ok;
        int v0, e0;
        v0 = n_rxv;
        e0 = n_rxe;
        host_send(8'hF4, 1'b1, 1'b0, pulses, ack, ok);
        checks++;
        if (!ok || pulses != 11 || ack !== 1'b0) begin
            failures++;
            $display("FAIL par_ack pulses=%0d ack=%b want=11 0", pulses, ack);
        end
        checks++;
        if (n_rxe - e0 != 1 || n_rxv != v0) begin
            failures++;
            $display("FAIL par_flags err=%0d valid=%0d want=1 0", n_rxe - e0, n_rxv - v0);
        end
        checks++;
        if (rx_data !== 8'h00) begin
            failures++;
            $display("FAIL par_rx_data got=%h want=00", rx_data);
        end
        tick(20);
    endtask

    task automatic test_tx_abort();
        bit ok;
        bit fell;
        int a0, d0;
        time t_rel;
        logic [10:0] got;
        a0 = n_abort;
        d0 = n_done;
        send_byte(8'hFA, ok);
        fell = 1'b1;
        for (int i = 0; i < 3 && fell; i++) wait_fall(100, fell);
        wait_rise(20, ok);
        tick(1);
        host_clk_low = 1'b1;
        wait_cnt(1, a0, 20, ok);
        checks++;
        if (!fell || !ok || n_done != d0) begin
            failures++;
            $display("FAIL abort_pulse abort=%0d done=%0d want=1 0", n_abort - a0, n_done - d0);
        end
        tick(3);
        checks++;
        if (ps2_dat !== 1'b1 || tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_release dat=%b ready=%b want=1 0", ps2_dat, tx_ready);
        end
        tick(20);
        checks++;
        if (n_abort - a0 != 1 || n_done != d0) begin
            failures++;
            $display("FAIL abort_hold abort=%0d done=%0d want=1 0", n_abort - a0, n_done - d0);
        end
        clear_q();
        host_clk_low = 1'b0;
        t_rel = $time;
        wait_cnt(0, d0, 300, ok);
        got = '0;
        for (int i = 0; i < 11 && i < bit_q.size(); i++) got[i] = bit_q[i];
        checks++;
        if (!ok || bit_q.size() != 11 || got !== FRAME_FA) begin
            failures++;
            $display("FAIL abort_resend done=%0d bits=%0d got=%b want=1 11 %b",
                     ok, bit_q.size(), got, FRAME_FA);
        end
        checks++;
        if (time_q.size() == 0 || time_q[0] - t_rel < (IDLE_CYCLES + CLK_HALF) * 10) begin
            failures++;
            $display("FAIL abort_idle_gap got=%0t want>=%0d",
                     (time_q.size() == 0) ? 0 : time_q[0] - t_rel, (IDLE_CYCLES + CLK_HALF) * 10);
        end
        tick(20);
    endtask

    task automatic test_reset_midframe();
        bit ok;
        bit fell;
        int d0;
        d0 = n_done;
        send_byte(8'hFA, ok);
        fell = 1'b1;
        for (int i = 0; i < 6 && fell; i++) wait_fall(100, fell);
        tick(1);
        checks++;
        if (!fell || ps2_clk !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_setup clk=%b want=0", ps2_clk);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ps2_clk, ps2_dat} !== 2'b11) begin
            failures++;
            $display("FAIL rst_mid_lines got=%b want=11", {ps2_clk, ps2_dat});
        end
        checks++;
        if ({tx_ready, tx_done, tx_abort, rx_valid, rx_error} !== 5'b0) begin
            failures++;
            $display("FAIL rst_mid_flags got=%b want=00000",
                     {tx_ready, tx_done, tx_abort, rx_valid, rx_error});
        end
        tick(3);
        rst_n = 1'b1;
        clear_q();
        tick(200);
        checks++;
        if (bit_q.size() != 0 || n_done != d0 || tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_no_resend falls=%0d done=%0d ready=%b want=0 0 1",
                     bit_q.size(), n_done - d0, tx_ready);
        end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_rx_ok();
        test_rts_priority();
        test_rx_parity_error();
        test_tx_abort();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
